div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 divCtrl  input  1  start request, sampled on rising clk while idle.
REQ-005 srcA  input  32  dividend, two's complement.
REQ-006 srcB  input  32  divisor, two's complement.
REQ-007 hi  output  32  remainder of last completed division, registered.
REQ-008 lo  output  32  quotient of last completed division, registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse marking new hi/lo values.
REQ-011 divZero  output  1  high when the last completed division had srcB == 0.

Function
REQ-012 FSM states SHALL be IDLE, RUN and FINISH, and busy SHALL equal (state != IDLE).
REQ-013 In IDLE with divCtrl=1 at edge E0, the block SHALL capture |srcA| and |srcB| plus both sign bits, clear the partial remainder, load iteration counter 32, and enter RUN.
REQ-014 Operands SHALL be sampled only at E0; later srcA/srcB changes SHALL not affect the result.
REQ-015 Each RUN cycle SHALL do one restoring step: shift {rem,quot} left 1, subtract the divisor magnitude from rem when rem >= divisor, set quot LSB accordingly, and decrement the counter.
REQ-016 The partial remainder SHALL be 33 bits wide so that the compare and subtract never overflow.
REQ-017 After 32 RUN steps (edges E1..E32) the FSM SHALL enter FINISH.
REQ-018 At the FINISH edge E33 the block SHALL register lo and hi, pulse done for the following cycle, clear busy, and return to IDLE.
REQ-019 lo SHALL be negated when srcA[31] XOR srcB[31] is set.
REQ-020 hi SHALL take the sign of the dividend (truncation toward zero, MIPS DIV semantics).
REQ-021 Total latency from the start edge to done high SHALL be 33 cycles for any nonzero divisor.
REQ-022 divCtrl SHALL be ignored while busy=1; no restart, no queuing.
REQ-023 A start in the cycle where done=1 SHALL be accepted, because that cycle is IDLE.
REQ-024 If srcB == 0 at E0, the FSM SHALL go directly to FINISH; at E1 it SHALL set hi=0, lo=0 and divZero=1, then pulse done after E1.
REQ-025 divZero SHALL hold until the next completion and SHALL be cleared at the next non-zero completion.
REQ-026 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0 with no flag; the overflow SHALL be silently wrapped.
REQ-027 hi, lo and divZero SHALL hold their values between completions, and SHALL stay unchanged while busy.

Reset
REQ-028 While reset=0, the block SHALL immediately force state=IDLE, hi=0, lo=0, busy=0, done=0, divZero=0, and clear the internal counter, remainder and quotient, independent of clk.
REQ-029 Reset asserted mid-division SHALL abort the operation with no done pulse and no change to outputs other than the reset values.
REQ-030 After reset deasserts, the first rising clk with divCtrl=1 SHALL start a division normally.

Verification
REQ-031 srcA=7, srcB=2, divCtrl pulsed one cycle -> busy for 33 cycles, done at cycle 33, lo=3, hi=1, divZero=0.
REQ-032 srcA=0xFFFFFFF9 (-7), srcB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then srcA=7, srcB=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
REQ-033 srcB=0, srcA=0x1234 -> done one cycle after start, hi=0, lo=0, divZero=1; next 9/3 -> lo=3, hi=0, divZero=0.
REQ-034 srcA=0x80000000, srcB=0xFFFFFFFF -> lo=0x80000000, hi=0; srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> lo=1, hi=0.
REQ-035 Start 100/7, change srcA/srcB and pulse divCtrl at cycle 5 -> single done at cycle 33, lo=14, hi=2.
REQ-036 Start 100/7, assert reset=0 at cycle 10 -> all outputs 0 at once, no done; after release, 100/7 -> lo=14, hi=2 at 33 cycles.

Source files
------------

// File: rtl/div.sv
// Multi-cycle 32-bit signed divider: restoring algorithm, one quotient bit per cycle.
// Truncates toward zero; remainder takes the dividend's sign; divide-by-zero sets divZero.
module div (
    input  logic        clk,
    input  logic        reset,
    input  logic        divCtrl,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        divZero
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } state_e;

    state_e      state_q;
    logic [32:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] divisor_q;
    logic [5:0]  count_q;
    logic        neg_quot_q;
    logic        neg_rem_q;
    logic        zero_q;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        step_ge;
    logic [31:0] quot_fin;
    logic [31:0] rem_fin;
    logic        unused_rem_msb;

    // Magnitudes are taken as unsigned, so |0x80000000| is 0x80000000 without overflow.
    assign a_mag = srcA[31] ? (32'd0 - srcA) : srcA;
    assign b_mag = srcB[31] ? (32'd0 - srcB) : srcB;

    // After every step rem < divisor <= 2^31, so the stored MSB is always zero and the
    // shifted value needs only rem[31:0]; the 33-bit width keeps compare/subtract exact.
    assign rem_shift      = {rem_q[31:0], quot_q[31]};
    assign step_ge        = (rem_shift >= {1'b0, divisor_q});
    assign rem_diff       = rem_shift - {1'b0, divisor_q};
    assign unused_rem_msb = rem_q[32];

    assign quot_fin = neg_quot_q ? (32'd0 - quot_q) : quot_q;
    assign rem_fin  = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            count_q    <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
            divZero    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (divCtrl) begin
                        divisor_q  <= b_mag;
                        quot_q     <= a_mag;
                        rem_q      <= '0;
                        count_q    <= 6'd32;
                        neg_quot_q <= srcA[31] ^ srcB[31];
                        neg_rem_q  <= srcA[31];
                        zero_q     <= (srcB == 32'd0);
                        state_q    <= (srcB == 32'd0) ? StFinish : StRun;
                    end
                end
                StRun: begin
                    rem_q   <= step_ge ? rem_diff : rem_shift;
                    quot_q  <= {quot_q[30:0], step_ge};
                    count_q <= count_q - 6'd1;
                    if (count_q == 6'd1) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    if (zero_q) begin
                        hi      <= '0;
                        lo      <= '0;
                        divZero <= 1'b1;
                    end else begin
                        hi      <= rem_fin;
                        lo      <= quot_fin;
                        divZero <= 1'b0;
                    end
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: stimulus pushes expected results, a monitor checks each done pulse.
module tb_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        divCtrl;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        divZero;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        int          start;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    div dut (
        .clk    (clk),
        .reset  (reset),
        .divCtrl(divCtrl),
        .srcA   (srcA),
        .srcB   (srcB),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .divZero(divZero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no completion",
                         cyc);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, ".lo"}, lo, e.lo);
                chk({e.name, ".hi"}, hi, e.hi);
                chk({e.name, ".divZero"}, {31'd0, divZero}, {31'd0, e.zero});
                chk({e.name, ".latency"}, cyc - e.start, e.lat);
                chk({e.name, ".busy_at_done"}, {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic start_div(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eh, input logic [31:0] el, input logic ez,
                             input int lat, input string nm, input bit expect_done);
        srcA    = a;
        srcB    = b;
        divCtrl = 1'b1;
        if (expect_done) exp_q.push_back('{nm, eh, el, ez, cyc + 1, lat});
        @(posedge clk);
        #1;
        divCtrl = 1'b0;
        // Operands are scrambled after the start edge; they must not matter.
        srcA = ~a;
        srcB = b + 32'd1;
        chk({nm, ".busy_after_start"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
            #1;
        end
        tests++;
        fails++;
        $display("FAIL %s.timeout: got no done within 60 cycles, required done", nm);
        exp_q.delete();
    endtask

    initial begin
        reset   = 1'b0;
        divCtrl = 1'b0;
        srcA    = '0;
        srcB    = '0;
        repeat (2) @(negedge clk);
        chk("reset.hi", hi, 32'd0);
        chk("reset.lo", lo, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.divZero", {31'd0, divZero}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;

        start_div(32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33, "7/2", 1'b1);
        wait_done("7/2");
        repeat (3) @(negedge clk);
        chk("hold.lo", lo, 32'd3);
        chk("hold.hi", hi, 32'd1);
        #1;

        start_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, "-7/2", 1'b1);
        wait_done("-7/2");
        start_div(32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33, "7/-2", 1'b1);
        repeat (5) @(negedge clk);
        chk("busy_hold.lo", lo, 32'hFFFF_FFFD);
        chk("busy_hold.hi", hi, 32'hFFFF_FFFF);
        #1;
        wait_done("7/-2");

        start_div(32'h0000_1234, 32'd0, 32'd0, 32'd0, 1'b1, 1, "x/0", 1'b1);
        wait_done("x/0");
        // Started in the done cycle of the previous division.
        start_div(32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 33, "9/3", 1'b1);
        wait_done("9/3");

        start_div(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, "min/-1", 1'b1);
        wait_done("min/-1");
        start_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 33, "-1/-1", 1'b1);
        wait_done("-1/-1");

        start_div(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, "100/7_busy", 1'b1);
        repeat (3) @(negedge clk);
        srcA    = 32'd50;
        srcB    = 32'd3;
        divCtrl = 1'b1;
        @(posedge clk);
        #1;
        divCtrl = 1'b0;
        wait_done("100/7_busy");

        start_div(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 0, "abort", 1'b0);
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort.hi", hi, 32'd0);
        chk("abort.lo", lo, 32'd0);
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.divZero", {31'd0, divZero}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort.idle_busy", {31'd0, busy}, 32'd0);
        #1;
        start_div(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, "100/7_after_reset", 1'b1);
        wait_done("100/7_after_reset");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 time units, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
